lvds_frame_serializer: RTL
==========================

# lvds_frame_serializer

Transmit end of the 5-bit LVDS serial link. It accepts parallel payload words over a valid/ready handshake and buffers one word. Each word goes out as a frame: a `1` start/marker bit, then DATA_W payload bits MSB-first, then GAP idle-zero guard cycles. The receive-side 5-bit deserializer then sees its marker in bit 4 and returns to its clear state between frames.

## Interface
- DATA_W, 4, payload bits per frame; the frame is DATA_W+1 bits, 5 with the default.
- GAP, 2, idle `0` cycles after each frame's last data bit; legal range ≥1.
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- data_i  input  DATA_W  payload word, sampled on accept.
- valid_i  input  1  data_i valid.
- ready_o  output  1  buffer empty, word can be accepted; `!buf_valid && !reset`.
- serial_o  output  1  serial line, registered; idle level `0`.
- busy_o  output  1  FSM not in IDLE (registered state decode).
- done_o  output  1  one-cycle pulse coincident with the last data bit on serial_o.

## Operation
- Accept: on a rising edge with valid_i && ready_o, data_i is written to the holding buffer and buf_valid is set. data_i is ignored when ready_o=0.
- Internal state: holding buffer, shift register (DATA_W), bit counter (clog2(DATA_W+1)), gap counter (clog2(GAP+1)).
- IDLE: serial_o=0. If buf_valid, go to START: load the shift register from the buffer, clear buf_valid, drive serial_o=1.
- START (1 cycle): serial_o=1. Next state is DATA; drive serial_o to the shift register MSB and shift left.
- DATA (DATA_W cycles): serial_o carries payload bits MSB→LSB. done_o=1 in the cycle of the final bit. Then go to GAP with serial_o=0 and the gap counter loaded with GAP.
- GAP (GAP cycles): serial_o=0. On the last gap cycle:
  - if buf_valid, go directly to START with buffer load as above; there is no IDLE cycle between frames;
  - else go to IDLE.
- The buffer may be filled during any state. A word accepted while a frame is in flight waits; it is never lost or overwritten, because ready_o=0 while buf_valid=1.
- Simultaneous buffer load into the shift register and new accept in the same edge: not possible, since ready_o=0 while buf_valid=1. The accept takes effect from the next edge.
- Reset asserted (any time, mid-frame included):
  - state=IDLE, serial_o=0, busy_o=0, done_o=0;
  - buf_valid=0; buffer and shift register contents are don't-care;
  - the in-flight frame is truncated and not resumed.
- After reset deassertion, ready_o=1 at the first edge.

## Timing
- Reset values: serial_o=0, busy_o=0, done_o=0, ready_o=0 (while reset high), then 1.
- Latency: word accepted at edge N with the FSM in IDLE → START at edge N+1 → serial_o=1 during cycle N+1..N+2. Payload MSB appears after edge N+2, and the last bit with done_o after edge N+1+DATA_W.
- ready_o returns high after edge N+1 (the buffer-to-shift load).
- Frame period with the buffer continuously refilled: 1+DATA_W+GAP cycles (7 at defaults). Throughput is one word per period.
- busy_o rises after edge N+1. It falls after the last GAP edge only if no word is buffered.
- All outputs except ready_o are flop outputs. ready_o is combinational from buf_valid and reset.

## Test plan
- Single word, defaults: accept 4'b1010 at edge N, then hold valid_i low.
  - serial_o from edge N+1: 1,1,0,1,0,0,0, then 0 steady.
  - done_o high only in the 5th serial cycle; busy_o high for exactly 7 cycles.
- Back-to-back: hold valid_i=1 with words 4'hF, 4'h0, 4'h9.
  - serial_o = 11111 00 10000 00 11001 00 with no extra idle cycles.
  - ready_o pulses high once per frame; each word is accepted exactly once.
- Backpressure: present 4'h3 while ready_o=0 and change data_i to 4'hC before ready_o rises.
  - Only 4'hC is transmitted: 1,1,1,0,0.
- Reset mid-frame: assert reset asynchronously during the 2nd data bit of 4'b0110.
  - serial_o, busy_o and done_o go 0 immediately without waiting for an edge; ready_o=0 during reset.
  - After release, ready_o=1; a new 4'h5 is sent as 1,0,1,0,1.
- Parameter sweep with DATA_W=8, GAP=1: send 8'hA5.
  - serial_o = 1,1,0,1,0,0,1,0,1,0; frame period 10 cycles.
  - done_o on the 9th serial cycle.

Source files
------------

// File: rtl/lvds_frame_serializer.sv
// lvds_frame_serializer: buffered word-to-frame serializer (marker bit, MSB-first payload, zero guard gap)
module lvds_frame_serializer #(
  parameter int DATA_W = 4,
  parameter int GAP = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              serial_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam int GW = $clog2(GAP + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, GUARD} state_t;
  state_t state, state_n;
  logic buf_valid, load, serial_n, done_n;
  logic [DATA_W-1:0] buf_data, shreg, shreg_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [GW-1:0] gcnt, gcnt_n;
  assign ready_o = !buf_valid && !reset;
  always_comb begin
    state_n = state; shreg_n = shreg; cnt_n = cnt; gcnt_n = gcnt;
    serial_n = 1'b0; done_n = 1'b0; load = 1'b0;
    case (state)
      IDLE: load = buf_valid;
      START: begin
        state_n = DATA; serial_n = shreg[DATA_W-1]; shreg_n = shreg << 1;
        cnt_n = CW'(1); done_n = (DATA_W == 1);
      end
      DATA:
        if (cnt == CW'(DATA_W)) begin
          state_n = GUARD; gcnt_n = GW'(GAP);
        end else begin
          serial_n = shreg[DATA_W-1]; shreg_n = shreg << 1;
          cnt_n = cnt + CW'(1); done_n = (cnt + CW'(1) == CW'(DATA_W));
        end
      GUARD:
        if (gcnt == GW'(1)) begin
          state_n = IDLE; load = buf_valid;
        end else gcnt_n = gcnt - GW'(1);
      default: state_n = IDLE;
    endcase
    // a buffered word starts its frame straight from IDLE or the last guard cycle
    if (load) begin
      state_n = START; shreg_n = buf_data; serial_n = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE; buf_valid <= 1'b0; buf_data <= '0; shreg <= '0; cnt <= '0; gcnt <= '0;
      serial_o <= 1'b0; busy_o <= 1'b0; done_o <= 1'b0;
    end else begin
      state <= state_n; shreg <= shreg_n; cnt <= cnt_n; gcnt <= gcnt_n;
      serial_o <= serial_n; done_o <= done_n; busy_o <= (state_n != IDLE);
      if (load) buf_valid <= 1'b0;
      else if (valid_i && ready_o) begin
        buf_valid <= 1'b1; buf_data <= data_i;
      end
    end
endmodule
